iomem_arbiter: RTL and testbench
================================

Name: iomem_arbiter

Overview:
- Round-robin arbiter that shares one picosoc-style iomem slave port between two masters.
- Master 0 is the picosoc iomem port. Master 1 is the network-accelerator DMA/config engine.
- Sits between the SoC iomem bus and the peripheral decode (gpio block and accelerator CSRs).
- Sequences exactly one transaction at a time. Registers the request on grant and returns the response one cycle after the slave completes.

Parameters:
- TIMEOUT_CYCLES, 1024, slave cycles allowed before abort (used only with the optional feature); must be >= 2.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on an aborted transaction.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_valid  in  1  master 0 request; held until m0_ready
- m0_ready  out  1  master 0 completion pulse
- m0_wstrb  in  4  master 0 byte strobes; 0 = read
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_rdata  out  32  master 0 read data, valid with m0_ready
- m1_valid, m1_ready, m1_wstrb, m1_addr, m1_wdata, m1_rdata: same as master 0, for master 1
- s_valid  out  1  slave request
- s_ready  in  1  slave completion
- s_wstrb  out  4  slave byte strobes
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_rdata  in  32  slave read data
- grant  out  2  one-hot owner of the current transaction; 0 when idle
- timeout_err  out  1  sticky abort flag

Behaviour:
- Single clock clk. Asynchronous active-low reset resetn.
- Reset values:
  - state = IDLE.
  - s_valid, s_wstrb, s_addr, s_wdata = 0.
  - m0_ready, m1_ready = 0; m0_rdata, m1_rdata = 0.
  - grant = 0; timeout_err = 0.
  - last_grant = 1, so master 0 wins the first tie.
- All outputs are registered.
- IDLE:
  - No valid: stay in IDLE.
  - Exactly one valid: grant that master.
  - Both valid: grant the master other than last_grant.
  - On grant, capture that master's addr/wdata/wstrb into s_*, set s_valid=1, set grant one-hot, update last_grant, go to BUSY.
- BUSY:
  - s_valid is held at 1 and s_* are stable.
  - When s_ready=1: capture s_rdata into the granted master's rdata, pulse that master's ready for exactly one cycle (next cycle), set s_valid=0, go to RESP.
  - The other master's ready and rdata are unchanged.
- RESP (one cycle):
  - Ready pulse is high; s_valid=0.
  - All valid inputs are ignored, since the master still holds valid this cycle.
  - At the end of the cycle, clear ready and grant and go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 gives s_valid high at cycle 1.
  - Slave ready at cycle k gives master ready at cycle k+1.
  - Minimum 3 cycles for a single-cycle slave.
  - Back-to-back throughput: one transaction per 3 + slave-wait cycles.
- Fairness:
  - A master with valid held is served within one transaction of the other master.
  - Alternation is strict when both masters are continuously requesting.
- s_ready while IDLE or RESP: ignored.
- Master drops valid while BUSY (protocol violation):
  - The slave transaction still completes.
  - The ready pulse is still issued.
  - The rdata is still updated.
- rdata is updated on writes too, with the slave's s_rdata value; masters ignore it.
- Asynchronous reset mid-transaction:
  - All outputs go to their reset values immediately.
  - The in-flight transaction is dropped, with no ready pulse.
  - last_grant returns to 1.

Optional Feature:
- Macro: IOMEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle with s_ready=0.
  - When the count reaches TIMEOUT_CYCLES-1 with s_ready=0, abort: s_valid=0, granted master rdata=TIMEOUT_RDATA, ready pulse, go to RESP, set timeout_err=1.
  - timeout_err is sticky until reset.
  - If s_ready=1 in the same cycle as the limit, the normal completion wins.
  - A late s_ready after an abort is ignored.
- Undefined:
  - No counter.
  - BUSY waits indefinitely.
  - timeout_err is constant 0.

Test Plan:
- Write, master 0 only: m0 write addr 0x0300_0000, wdata 0x1234_5678, wstrb 4'hF; slave ready 1 cycle after s_valid.
  - Required: s_addr/s_wdata/s_wstrb match; grant=2'b01; m0_ready is a single pulse exactly 1 cycle after s_ready; m1_ready never asserts.
- Read, master 1 only: m1 read addr 0x0300_0004; slave returns 0xCAFE_F00D after 3 wait cycles.
  - Required: m1_rdata = 0xCAFE_F00D with m1_ready; total latency 6 cycles.
- Tie out of reset: m0 and m1 both valid continuously for 4 transactions each.
  - Required: grant order m0, m1, m0, m1, ...; no master is served twice in a row; s_valid low in each RESP cycle.
- Reset mid-transaction: assert resetn=0 while BUSY with m1 granted; release; then raise both valids.
  - Required: outputs reach reset values asynchronously; no ready pulse; first grant afterwards is m0.
- Spurious slave ready: s_ready=1 while IDLE, and again during RESP.
  - Required: no master ready pulse; state unaffected.
- Timeout (IOMEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8): m0 read; slave never readies.
  - Required: m0_ready pulses with m0_rdata = 0xDEAD_BEEF; timeout_err latches 1.
  - Repeat with s_ready at the limit cycle: normal rdata is returned and timeout_err is not set.

Source files
------------

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing one picosoc iomem slave between two masters, one transaction at a time.
// Optional slave timeout/abort is enabled by defining IOMEM_ARB_TIMEOUT_EN.
module iomem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic        last_grant_r;   // 0: master 0 served last, 1: master 1 served last
    logic        pick_m1_s;
    logic        done_s;
    logic        abort_s;
    logic [31:0] done_data_s;

`ifdef IOMEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_r;
`endif

    // Arbitration choice: a lone requester wins, a tie goes to the master not served last.
    always_comb begin
        pick_m1_s = 1'b0;
        if (m0_valid && m1_valid) begin
            pick_m1_s = ~last_grant_r;
        end else if (m1_valid) begin
            pick_m1_s = 1'b1;
        end else begin
            pick_m1_s = 1'b0;
        end
    end

    // Completion detect; a real s_ready takes priority over a timeout in the same cycle.
    always_comb begin
        done_s  = 1'b0;
        abort_s = 1'b0;
        if ((state_r == BUSY) && s_ready) begin
            done_s = 1'b1;
        end
`ifdef IOMEM_ARB_TIMEOUT_EN
        else if ((state_r == BUSY) && (cnt_r == CNT_LIMIT)) begin
            done_s  = 1'b1;
            abort_s = 1'b1;
        end
`endif
        else begin
            done_s  = 1'b0;
            abort_s = 1'b0;
        end
        done_data_s = abort_s ? TIMEOUT_RDATA : s_rdata;
    end

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            s_valid      <= 1'b0;
            s_wstrb      <= 4'h0;
            s_addr       <= 32'h0000_0000;
            s_wdata      <= 32'h0000_0000;
            m0_ready     <= 1'b0;
            m1_ready     <= 1'b0;
            m0_rdata     <= 32'h0000_0000;
            m1_rdata     <= 32'h0000_0000;
            grant        <= 2'b00;
            timeout_err  <= 1'b0;
`ifdef IOMEM_ARB_TIMEOUT_EN
            cnt_r        <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        state_r      <= BUSY;
                        s_valid      <= 1'b1;
                        last_grant_r <= pick_m1_s;
                        grant        <= pick_m1_s ? 2'b10 : 2'b01;
                        s_addr       <= pick_m1_s ? m1_addr  : m0_addr;
                        s_wdata      <= pick_m1_s ? m1_wdata : m0_wdata;
                        s_wstrb      <= pick_m1_s ? m1_wstrb : m0_wstrb;
`ifdef IOMEM_ARB_TIMEOUT_EN
                        cnt_r        <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (done_s) begin
                        state_r <= RESP;
                        s_valid <= 1'b0;
                        if (abort_s) begin
                            timeout_err <= 1'b1;
                        end
                        if (grant[1]) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= done_data_s;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= done_data_s;
                        end
                    end
`ifdef IOMEM_ARB_TIMEOUT_EN
                    else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    // Masters still hold valid this cycle, so requests are not looked at here.
                    state_r  <= IDLE;
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    grant    <= 2'b00;
                end
                default: begin
                    state_r  <= IDLE;
                    s_valid  <= 1'b0;
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    grant    <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Self-checking bench for iomem_arbiter: directed scenarios plus randomized traffic against a round-robin model.
module tb_iomem_arbiter;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_ready, timeout_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;
    int rdy0_cnt = 0;
    int rdy1_cnt = 0;

    // Reference model state: who was served last, and each master's last returned data.
    bit          last_m1;
    logic [31:0] exp_rd0, exp_rd1;

    iomem_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count ready-high cycles to catch stretched or missing pulses.
    always @(negedge clk) begin
        if (m0_ready) rdy0_cnt++;
        if (m1_ready) rdy1_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        resetn = 1'b0;
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        m0_wstrb = 4'h0; m1_wstrb = 4'h0;
        m0_addr = 32'h0; m0_wdata = 32'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        s_rdata = 32'h0;
        repeat (2) cyc();
        resetn = 1'b1;
        cyc();
        last_m1 = 1'b1;
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if ({s_valid, s_wstrb, s_addr, s_wdata} !== 69'h0) begin
            errors++; $display("FAIL reset_slave: got %h required 0", {s_valid, s_wstrb, s_addr, s_wdata});
        end
        checks++;
        if ({m0_ready, m1_ready, m0_rdata, m1_rdata, grant, timeout_err} !== 69'h0) begin
            errors++; $display("FAIL reset_master: got %h required 0", {m0_ready, m1_ready, m0_rdata, m1_rdata, grant, timeout_err});
        end
    endtask

    task automatic test_write_m0;
        int c0, c1;
        c0 = rdy0_cnt; c1 = rdy1_cnt;
        m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wdata = 32'h1234_5678; m0_wstrb = 4'hF;
        cyc();
        checks++;
        if ({s_valid, grant} !== 3'b101) begin
            errors++; $display("FAIL wr_grant: got valid/grant %b required 101", {s_valid, grant});
        end
        checks++;
        if ({s_addr, s_wdata, s_wstrb} !== {32'h0300_0000, 32'h1234_5678, 4'hF}) begin
            errors++; $display("FAIL wr_fields: got %h %h %h", s_addr, s_wdata, s_wstrb);
        end
        cyc();
        s_ready = 1'b1; s_rdata = 32'h0000_00A5;
        checks++;
        if (m0_ready !== 1'b0) begin
            errors++; $display("FAIL wr_early_ready: got %b required 0", m0_ready);
        end
        cyc();
        s_ready = 1'b0;
        checks++;
        if ({m0_ready, s_valid, m0_rdata} !== {1'b1, 1'b0, 32'h0000_00A5}) begin
            errors++; $display("FAIL wr_resp: got ready=%b s_valid=%b rdata=%h required 1 0 000000a5", m0_ready, s_valid, m0_rdata);
        end
        m0_valid = 1'b0;
        cyc();
        checks++;
        if ({m0_ready, grant} !== 3'b000) begin
            errors++; $display("FAIL wr_idle: got ready=%b grant=%b required 0 00", m0_ready, grant);
        end
        cyc();
        checks++;
        if ((rdy0_cnt - c0) != 1 || (rdy1_cnt - c1) != 0) begin
            errors++; $display("FAIL wr_pulses: got m0=%0d m1=%0d required 1 0", rdy0_cnt - c0, rdy1_cnt - c1);
        end
        last_m1 = 1'b0; exp_rd0 = 32'h0000_00A5;
    endtask

    task automatic test_read_m1;
        int sv, lat, c0;
        bit got;
        sv = 0; lat = 0; got = 1'b0; c0 = rdy0_cnt;
        m1_valid = 1'b1; m1_addr = 32'h0300_0004; m1_wdata = $urandom; m1_wstrb = 4'h0;
        for (int e = 1; e <= 30 && !got; e++) begin
            cyc();
            if (m1_ready) begin
                got = 1'b1; lat = e + 1; s_ready = 1'b0;
            end else begin
                if (s_valid) sv++;
                s_ready = s_valid && (sv == 4);
                s_rdata = 32'hCAFE_F00D;
            end
        end
        s_ready = 1'b0;
        checks++;
        if (!got || lat != 6) begin
            errors++; $display("FAIL rd_latency: got seen=%0d latency=%0d required 1 6", got, lat);
        end
        checks++;
        if (m1_rdata !== 32'hCAFE_F00D || rdy0_cnt != c0) begin
            errors++; $display("FAIL rd_data: got %h m0 pulses %0d required cafef00d 0", m1_rdata, rdy0_cnt - c0);
        end
        m1_valid = 1'b0;
        cyc();
        last_m1 = 1'b1; exp_rd1 = 32'hCAFE_F00D;
    endtask

    task automatic test_tie;
        bit own_m1;
        int k;
        apply_reset();
        m0_valid = 1'b1; m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'h3;
        m1_valid = 1'b1; m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'hC;
        for (int t = 0; t < 8; t++) begin
            k = 0;
            while (!s_valid && k < 10) begin cyc(); k++; end
            own_m1 = !last_m1;
            checks++;
            if (s_valid !== 1'b1 || grant !== (own_m1 ? 2'b10 : 2'b01) || own_m1 != (t % 2 == 1)) begin
                errors++; $display("FAIL tie_grant%0d: got s_valid=%b grant=%b required 1 %b", t, s_valid, grant, own_m1 ? 2'b10 : 2'b01);
            end
            checks++;
            if (s_addr !== (own_m1 ? m1_addr : m0_addr)) begin
                errors++; $display("FAIL tie_addr%0d: got %h required %h", t, s_addr, own_m1 ? m1_addr : m0_addr);
            end
            s_ready = 1'b1; s_rdata = $urandom;
            cyc();
            s_ready = 1'b0;
            checks++;
            if ({s_valid, m1_ready, m0_ready} !== {1'b0, own_m1, !own_m1}) begin
                errors++; $display("FAIL tie_resp%0d: got s_valid/m1/m0 %b required 0%b%b", t, {s_valid, m1_ready, m0_ready}, own_m1, !own_m1);
            end
            last_m1 = own_m1;
            if (own_m1) begin exp_rd1 = s_rdata; m1_addr = $urandom; end
            else begin exp_rd0 = s_rdata; m0_addr = $urandom; end
            cyc();
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        k = 0;
        while (s_valid && k < 10) begin
            s_ready = 1'b1; cyc(); s_ready = 1'b0; cyc(); k++;
        end
        cyc();
        apply_reset();
    endtask

    task automatic test_reset_mid;
        int c1;
        m0_valid = 1'b0; m1_valid = 1'b1; m1_addr = 32'h0300_0010; m1_wstrb = 4'h0;
        cyc();
        checks++;
        if (grant !== 2'b10) begin
            errors++; $display("FAIL rstmid_pre: got grant %b required 10", grant);
        end
        c1 = rdy1_cnt;
        s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({s_valid, s_wstrb, s_addr, s_wdata, m0_ready, m1_ready, m0_rdata, m1_rdata, grant, timeout_err} !== 138'h0) begin
            errors++; $display("FAIL rstmid_async: outputs not at reset values, grant=%b s_valid=%b", grant, s_valid);
        end
        cyc(); cyc();
        s_ready = 1'b0;
        resetn = 1'b1;
        last_m1 = 1'b1; exp_rd0 = 32'h0; exp_rd1 = 32'h0;
        checks++;
        if (rdy1_cnt != c1) begin
            errors++; $display("FAIL rstmid_pulse: got %0d m1 pulses required 0", rdy1_cnt - c1);
        end
        m0_valid = 1'b1;
        cyc();
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL rstmid_first: got grant %b required 01", grant);
        end
        s_ready = 1'b1; s_rdata = 32'h0000_1111;
        cyc();
        s_ready = 1'b0; m0_valid = 1'b0; exp_rd0 = 32'h0000_1111;
        cyc();
        cyc();
        checks++;
        if (grant !== 2'b10) begin
            errors++; $display("FAIL rstmid_second: got grant %b required 10", grant);
        end
        s_ready = 1'b1; s_rdata = 32'h0000_2222;
        cyc();
        s_ready = 1'b0; m1_valid = 1'b0; exp_rd1 = 32'h0000_2222;
        cyc();
        last_m1 = 1'b1;
    endtask

    task automatic test_spurious;
        int c0, c1;
        c0 = rdy0_cnt; c1 = rdy1_cnt;
        s_ready = 1'b1; s_rdata = 32'h0BAD_0BAD;
        repeat (3) cyc();
        checks++;
        if ({s_valid, grant, m0_ready, m1_ready} !== 5'b0 || rdy0_cnt != c0 || rdy1_cnt != c1) begin
            errors++; $display("FAIL spur_idle: got s_valid=%b grant=%b pulses=%0d required idle", s_valid, grant, rdy0_cnt + rdy1_cnt - c0 - c1);
        end
        s_ready = 1'b0;
        m0_valid = 1'b1; m0_addr = $urandom; m0_wstrb = 4'h0;
        cyc();
        s_ready = 1'b1; s_rdata = 32'h7777_0001;
        cyc();
        m0_valid = 1'b0; s_rdata = 32'h7777_0002;
        cyc();
        cyc();
        s_ready = 1'b0;
        checks++;
        if (rdy0_cnt - c0 != 1 || m0_rdata !== 32'h7777_0001 || {s_valid, grant} !== 3'b000) begin
            errors++; $display("FAIL spur_resp: got pulses=%0d rdata=%h required 1 77770001", rdy0_cnt - c0, m0_rdata);
        end
        exp_rd0 = 32'h7777_0001; last_m1 = 1'b0;
        m1_valid = 1'b1; m1_addr = 32'h0300_0020;
        cyc();
        checks++;
        if ({s_valid, grant} !== 3'b110 || s_addr !== 32'h0300_0020) begin
            errors++; $display("FAIL spur_after: got s_valid/grant %b addr %h required 110 03000020", {s_valid, grant}, s_addr);
        end
        s_ready = 1'b1; s_rdata = 32'h0000_3333;
        cyc();
        s_ready = 1'b0; m1_valid = 1'b0; exp_rd1 = 32'h0000_3333; last_m1 = 1'b1;
        cyc();
    endtask

`ifdef IOMEM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        apply_reset();
        m0_valid = 1'b1; m0_addr = 32'h0300_0040; m0_wstrb = 4'h0;
        cyc();
        repeat (7) cyc();
        checks++;
        if ({s_valid, m0_ready} !== 2'b10) begin
            errors++; $display("FAIL to_limit_busy: got s_valid/ready %b required 10", {s_valid, m0_ready});
        end
        s_ready = 1'b1; s_rdata = 32'h1357_2468;
        cyc();
        s_ready = 1'b0;
        checks++;
        if ({m0_ready, timeout_err} !== 2'b10 || m0_rdata !== 32'h1357_2468) begin
            errors++; $display("FAIL to_limit_resp: got ready=%b err=%b rdata=%h required 1 0 13572468", m0_ready, timeout_err, m0_rdata);
        end
        m0_valid = 1'b0;
        cyc();
        apply_reset();
        m0_valid = 1'b1;
        cyc();
        n = 0;
        for (int e = 0; e < 40 && !m0_ready; e++) begin
            if (s_valid) n++;
            cyc();
        end
        checks++;
        if (m0_ready !== 1'b1 || n != 8 || m0_rdata !== 32'hDEAD_BEEF || timeout_err !== 1'b1) begin
            errors++; $display("FAIL to_abort: got ready=%b busy=%0d rdata=%h err=%b required 1 8 deadbeef 1", m0_ready, n, m0_rdata, timeout_err);
        end
        s_ready = 1'b1; s_rdata = 32'h0000_9999; m0_valid = 1'b0;
        cyc();
        s_ready = 1'b0;
        cyc();
        checks++;
        if ({m0_ready, grant, timeout_err} !== 4'b0001 || m0_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL to_sticky: got ready=%b grant=%b err=%b rdata=%h required 0 00 1 deadbeef", m0_ready, grant, timeout_err, m0_rdata);
        end
        apply_reset();
    endtask
`else
    task automatic test_timeout;
        m0_valid = 1'b1; m0_addr = 32'h0300_0040; m0_wstrb = 4'h0;
        cyc();
        repeat (20) cyc();
        checks++;
        if ({s_valid, m0_ready, timeout_err} !== 3'b100) begin
            errors++; $display("FAIL no_timeout: got s_valid/ready/err %b required 100", {s_valid, m0_ready, timeout_err});
        end
        s_ready = 1'b1; s_rdata = 32'h0000_4444;
        cyc();
        s_ready = 1'b0; m0_valid = 1'b0;
        cyc();
        apply_reset();
    endtask
`endif

    task automatic test_random;
        bit p0, p1, own_m1;
        logic [31:0] a0, d0, a1, d1, rd;
        logic [3:0] w0, w1;
        int wt;
        apply_reset();
        p0 = 1'b0; p1 = 1'b0;
        a0 = 0; d0 = 0; a1 = 0; d1 = 0; w0 = 0; w1 = 0;
        for (int it = 0; it < 60; it++) begin
            if (!p0 && $urandom_range(0, 1) == 1) begin
                p0 = 1'b1; a0 = $urandom; d0 = $urandom; w0 = 4'($urandom_range(0, 15));
            end
            if (!p1 && $urandom_range(0, 1) == 1) begin
                p1 = 1'b1; a1 = $urandom; d1 = $urandom; w1 = 4'($urandom_range(0, 15));
            end
            if (!p0 && !p1) begin
                p0 = 1'b1; a0 = $urandom; d0 = $urandom; w0 = 4'($urandom_range(0, 15));
            end
            m0_valid = p0; m0_addr = a0; m0_wdata = d0; m0_wstrb = w0;
            m1_valid = p1; m1_addr = a1; m1_wdata = d1; m1_wstrb = w1;
            own_m1 = (p0 && p1) ? !last_m1 : p1;
            cyc();
            checks++;
            if ({s_valid, grant} !== {1'b1, own_m1, !own_m1}) begin
                errors++; $display("FAIL rnd_grant%0d: got s_valid/grant %b required 1%b%b", it, {s_valid, grant}, own_m1, !own_m1);
            end
            checks++;
            if ({s_addr, s_wdata, s_wstrb} !== (own_m1 ? {a1, d1, w1} : {a0, d0, w0})) begin
                errors++; $display("FAIL rnd_fields%0d: got %h %h %h", it, s_addr, s_wdata, s_wstrb);
            end
            last_m1 = own_m1;
            if ($urandom_range(0, 7) == 0) begin
                if (own_m1) m1_valid = 1'b0; else m0_valid = 1'b0;
            end
            wt = $urandom_range(0, 3);
            for (int w = 0; w < wt; w++) begin
                cyc();
                checks++;
                if ({s_valid, m0_ready, m1_ready} !== 3'b100) begin
                    errors++; $display("FAIL rnd_wait%0d: got s_valid/m0/m1 %b required 100", it, {s_valid, m0_ready, m1_ready});
                end
            end
            rd = $urandom;
            s_ready = 1'b1; s_rdata = rd;
            cyc();
            s_ready = 1'b0;
            if (own_m1) exp_rd1 = rd; else exp_rd0 = rd;
            checks++;
            if ({s_valid, m1_ready, m0_ready} !== {1'b0, own_m1, !own_m1}) begin
                errors++; $display("FAIL rnd_ready%0d: got s_valid/m1/m0 %b required 0%b%b", it, {s_valid, m1_ready, m0_ready}, own_m1, !own_m1);
            end
            checks++;
            if (m0_rdata !== exp_rd0 || m1_rdata !== exp_rd1) begin
                errors++; $display("FAIL rnd_rdata%0d: got %h %h required %h %h", it, m0_rdata, m1_rdata, exp_rd0, exp_rd1);
            end
            if (own_m1) begin p1 = 1'b0; m1_valid = 1'b0; end
            else begin p0 = 1'b0; m0_valid = 1'b0; end
            cyc();
            checks++;
            if ({m0_ready, m1_ready, grant, s_valid} !== 5'b0) begin
                errors++; $display("FAIL rnd_idle%0d: got %b required 00000", it, {m0_ready, m1_ready, grant, s_valid});
            end
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_write_m0();
        test_read_m1();
        test_tie();
        test_reset_mid();
        test_spurious();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
